// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sb_cfg_pkg : select encodings and config sizing for the corner switch block
// Revision   : 1.0
// ----------------------------------------------------------------------------
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    SEL_TOP   = 2'd0,
    SEL_PAD_A = 2'd1,
    SEL_PAD_B = 2'd2,
    SEL_ZERO  = 2'd3
  } sel_e;

  function automatic int cfg_bits(input int chan_w);
    return 2 * chan_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cfg_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sb_cfg_chain : serial shadow chain with bit counter and committed active copy
// Revision     : 1.0
// ----------------------------------------------------------------------------
module sb_cfg_chain #(
  parameter int CFG_BITS = 18
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head_i,
  input  logic                ccff_shift_en_i,
  input  logic                ccff_commit_i,
  output logic [CFG_BITS-1:0] active_o,
  output logic                cfg_valid_o,
  output logic                cfg_err_o,
  output logic                ccff_tail_o
);
  localparam int              CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                chain_full;

  assign chain_full = (cnt_q == FULL_CNT);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (ccff_shift_en_i) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head_i};
      if (!chain_full) cnt_d = cnt_q + CNT_W'(1);
    end
    // Commit samples the pre-shift shadow; a concurrent shift counts as the first new bit.
    if (ccff_commit_i) begin
      if (chain_full) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        cnt_d    = CNT_W'(ccff_shift_en_i);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign active_o    = active_q;
  assign cfg_valid_o = valid_q;
  assign cfg_err_o   = err_q;
  assign ccff_tail_o = shadow_q[CFG_BITS-1];

endmodule
`default_nettype wire

// File: rtl/sb_corner_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sb_corner_cfg : configurable corner switch block, top/right tracks and pads
// Revision      : 1.0
// ----------------------------------------------------------------------------
module sb_corner_cfg
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_W   = 9,
  parameter int NUM_PADS = 10
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic [CHAN_W-1:0]   chany_top_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  input  logic [NUM_PADS-1:0] pad_in,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic                ccff_tail,
  output logic                cfg_valid,
  output logic                cfg_err
);
  localparam int CFG_BITS = cfg_bits(CHAN_W);

  logic [CFG_BITS-1:0] active;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .ccff_head_i     (ccff_head),
    .ccff_shift_en_i (ccff_shift_en),
    .ccff_commit_i   (ccff_commit),
    .active_o        (active),
    .cfg_valid_o     (cfg_valid),
    .cfg_err_o       (cfg_err),
    .ccff_tail_o     (ccff_tail)
  );

  // Purely combinational from the registered active config, so a new commit swaps atomically.
  for (genvar i = 0; i < CHAN_W; i++) begin : g_track
    localparam int TOP_IDX = (i + CHAN_W - 1) % CHAN_W;
    localparam int PAD_A   = i % NUM_PADS;
    localparam int PAD_B   = (i + CHAN_W) % NUM_PADS;

    sel_e w_sel;
    logic w_src;

    assign w_sel = sel_e'(active[2*i+1 -: 2]);

    always_comb begin
      w_src = 1'b0;
      case (w_sel)
        SEL_TOP:   w_src = chany_top_in[TOP_IDX];
        SEL_PAD_A: w_src = pad_in[PAD_A];
        SEL_PAD_B: w_src = pad_in[PAD_B];
        SEL_ZERO:  w_src = 1'b0;
        default:   w_src = 1'b0;
      endcase
    end

    assign chanx_right_out[i]     = cfg_valid & w_src;
    assign chany_top_out[TOP_IDX] = cfg_valid & chanx_right_in[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_corner_cfg.sv
`default_nettype none
// Self-checking bench for sb_corner_cfg: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based behavioural model.
module tb_sb_corner_cfg;
  localparam int CW = 9;
  localparam int NP = 10;
  localparam int CB = 18;

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic [CW-1:0] chany_top_in;
  logic [CW-1:0] chanx_right_in;
  logic [NP-1:0] pad_in;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_commit;
  logic [CW-1:0] chany_top_out;
  logic [CW-1:0] chanx_right_out;
  logic          ccff_tail;
  logic          cfg_valid;
  logic          cfg_err;

  always #5 prog_clk = ~prog_clk;

  sb_corner_cfg #(.CHAN_W(CW), .NUM_PADS(NP)) dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .chany_top_in    (chany_top_in),
    .chanx_right_in  (chanx_right_in),
    .pad_in          (pad_in),
    .ccff_head       (ccff_head),
    .ccff_shift_en   (ccff_shift_en),
    .ccff_commit     (ccff_commit),
    .chany_top_out   (chany_top_out),
    .chanx_right_out (chanx_right_out),
    .ccff_tail       (ccff_tail),
    .cfg_valid       (cfg_valid),
    .cfg_err         (cfg_err)
  );

  int checks   = 0;
  int failures = 0;

  // Model: shadow as a bit queue (index 0 = newest), active as a committed snapshot.
  bit m_sh[$];
  bit m_act[CB];
  bit m_valid;
  bit m_err;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh.delete();
    for (int k = 0; k < CB; k++) m_sh.push_back(1'b0);
    for (int k = 0; k < CB; k++) m_act[k] = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  function automatic logic [CW-1:0] exp_right();
    logic [CW-1:0] r;
    r = '0;
    if (m_valid) begin
      for (int i = 0; i < CW; i++) begin
        int s;
        s = 2 * int'(m_act[2*i+1]) + int'(m_act[2*i]);
        case (s)
          0:       r[i] = chany_top_in[(i + CW - 1) % CW];
          1:       r[i] = pad_in[i % NP];
          2:       r[i] = pad_in[(i + CW) % NP];
          default: r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_top();
    logic [CW-1:0] r;
    r = '0;
    if (m_valid)
      for (int j = 0; j < CW; j++) r[(j + CW - 1) % CW] = chanx_right_in[j];
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".right"}, 32'(chanx_right_out), 32'(exp_right()));
    chk({tag, ".top"},   32'(chany_top_out),   32'(exp_top()));
    chk({tag, ".tail"},  32'(ccff_tail),       32'(m_sh[CB-1]));
    chk({tag, ".valid"}, 32'(cfg_valid),       32'(m_valid));
    chk({tag, ".err"},   32'(cfg_err),         32'(m_err));
  endtask

  task automatic tick(input bit rst, input bit sh, input bit head, input bit cm);
    prog_reset    = rst;
    ccff_shift_en = sh;
    ccff_head     = head;
    ccff_commit   = cm;
    @(posedge prog_clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      bit full;
      full = (m_cnt == CB);
      if (cm && full) begin
        for (int k = 0; k < CB; k++) m_act[k] = m_sh[k];
        m_valid = 1'b1;
        m_cnt   = sh ? 1 : 0;
      end else begin
        if (cm) m_err = 1'b1;
        if (sh && m_cnt < CB) m_cnt++;
      end
      if (sh) begin
        m_sh.push_front(head);
        void'(m_sh.pop_back());
      end
    end
    prog_reset    = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_commit   = 1'b0;
  endtask

  // First bit shifted lands in the top config bit, so send MSB first.
  task automatic load(input logic [CB-1:0] cfg);
    for (int k = CB - 1; k >= 0; k--) tick(1'b0, 1'b1, cfg[k], 1'b0);
  endtask

  initial begin
    logic [CB:0]   pat;
    logic [CW-1:0] rin;

    prog_reset = 1'b0; ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
    chany_top_in = '0; chanx_right_in = '0; pad_in = '0;
    model_reset();

    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.valid", 32'(cfg_valid), 32'd0);
    chk("rst.err",   32'(cfg_err),   32'd0);
    check_all("rst");

    // Unconfigured block keeps both outputs quiet.
    chanx_right_in = 9'h1FF; pad_in = '1; chany_top_in = CW'($urandom);
    #1;
    chk("noconf.right", 32'(chanx_right_out), 32'd0);
    chk("noconf.top",   32'(chany_top_out),   32'd0);
    chk("noconf.valid", 32'(cfg_valid),       32'd0);

    // All sel=0: right track i follows top track i-1.
    load('0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chany_top_in = 9'b000000001;
    rin = CW'($urandom);
    chanx_right_in = rin;
    #1;
    chk("sel0.right", 32'(chanx_right_out), 32'h002);
    chk("sel0.top",   32'(chany_top_out),   32'({rin[0], rin[CW-1:1]}));
    check_all("sel0");

    // Short chain commit flags an error and leaves the block unconfigured.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < CB - 1; k++) tick(1'b0, 1'b1, 1'($urandom), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("short.err",   32'(cfg_err),   32'd1);
    chk("short.valid", 32'(cfg_valid), 32'd0);
    check_all("short");
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("short.rst_err", 32'(cfg_err), 32'd0);

    // All sel=1 then all sel=3 with shift+commit together.
    load({9{2'b01}});
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    pad_in = 10'h2AA;
    #1;
    chk("pad.right", 32'(chanx_right_out), 32'h0AA);
    check_all("pad");
    load('1);
    chk("pad.hold", 32'(chanx_right_out), 32'h0AA);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("zero.right", 32'(chanx_right_out), 32'd0);
    chk("zero.valid", 32'(cfg_valid),       32'd1);
    check_all("zero");
    // The concurrent shift counted, so 17 more bits complete the chain.
    for (int k = 0; k < CB - 1; k++) tick(1'b0, 1'b1, 1'($urandom), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("recount.err", 32'(cfg_err), 32'd0);
    check_all("recount");

    // Tail reproduces the chain with an 18-cycle delay.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    pat = (CB+1)'($urandom);
    for (int k = 0; k < CB; k++) tick(1'b0, 1'b1, pat[k], 1'b0);
    chk("tail.first", 32'(ccff_tail), 32'(pat[0]));
    tick(1'b0, 1'b1, pat[CB], 1'b0);
    chk("tail.second", 32'(ccff_tail), 32'(pat[1]));

    // Reset mid-chain discards the partial load.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b1, 1'($urandom), 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b1, 1'($urandom), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst.err",   32'(cfg_err),   32'd1);
    chk("midrst.valid", 32'(cfg_valid), 32'd0);

    // Randomized run against the model.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom_range(0, 9) == 0));
      chany_top_in   = CW'($urandom);
      chanx_right_in = CW'($urandom);
      pad_in         = NP'($urandom);
      #1;
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
